// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : PC-source encodings and exception vectors shared by the
//               PC sequencer and the controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        PC_SRC_SEQ    = 3'd0,
        PC_SRC_BRANCH = 3'd1,
        PC_SRC_JUMP   = 3'd2,
        PC_SRC_JR     = 3'd3,
        PC_SRC_ILLOP  = 3'd4,
        PC_SRC_ERET   = 3'd5,
        PC_SRC_RSVD6  = 3'd6,
        PC_SRC_RSVD7  = 3'd7
    } pc_src_e;

    localparam logic [31:0] c_START_ADDR = 32'h0000_0000;
    localparam logic [31:0] c_ILLOP_ADDR = 32'h8000_0004;
    localparam logic [31:0] c_XADR_ADDR  = 32'h8000_0008;

endpackage
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : irq_arbiter
// Description : Rising-edge interrupt capture with lowest-index-first grant.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
    parameter int IRQ_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_take_ok,
    input  logic [IRQ_N-1:0] i_irq_in,
    input  logic [IRQ_N-1:0] i_irq_en,
    output logic             o_take,
    output logic [2:0]       o_cause
);

    logic [IRQ_N-1:0] r_prev;
    logic [IRQ_N-1:0] r_pending;
    logic [IRQ_N-1:0] w_req;
    logic [IRQ_N-1:0] w_lowest;
    logic [IRQ_N-1:0] w_clr;
    logic [2:0]       w_cause;

    assign w_req    = r_pending & i_irq_en;
    assign w_lowest = w_req & (-w_req);
    assign o_take   = i_take_ok & (|w_req);
    assign w_clr    = o_take ? w_lowest : '0;
    assign o_cause  = w_cause;

    always_comb begin
        w_cause = 3'd0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (w_req[i]) w_cause = 3'(i);
        end
    end

    // A fresh edge is OR-ed in after the clear so it survives a same-cycle grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= i_irq_in;
            r_pending <= (r_pending & ~w_clr) | (i_irq_in & ~r_prev);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter with branch/jump/exception sequencing, EPC
//               capture and edge-triggered interrupt vectoring.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          IRQ_N      = 4,
    parameter logic [31:0] START_ADDR = c_START_ADDR,
    parameter logic [31:0] ILLOP_ADDR = c_ILLOP_ADDR,
    parameter logic [31:0] XADR_ADDR  = c_XADR_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [2:0]        pc_src,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [25:0]       jump_index,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [IRQ_N-1:0]  irq_in,
    input  logic [IRQ_N-1:0]  irq_en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic              kernel,
    output logic              irq_take,
    output logic [2:0]        irq_cause
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_kernel;
    logic              w_take_ok;
    logic              w_illop;

    // The supervisor bit is never carried into; increments wrap in the low field.
    assign w_pc_plus4 = {r_pc[ADDR_W-1], r_pc[ADDR_W-2:0] + (ADDR_W-1)'(4)};
    assign w_kernel   = r_pc[ADDR_W-1];
    assign w_illop    = (pc_src == PC_SRC_ILLOP);
    assign w_take_ok  = advance & ~w_kernel & ~w_illop;

    irq_arbiter #(
        .IRQ_N (IRQ_N)
    ) u_irq_arbiter (
        .clk       (clk),
        .reset     (reset),
        .i_take_ok (w_take_ok),
        .i_irq_in  (irq_in),
        .i_irq_en  (irq_en),
        .o_take    (irq_take),
        .o_cause   (irq_cause)
    );

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pc_src)
            PC_SRC_SEQ:    w_next_pc = w_pc_plus4;
            PC_SRC_BRANCH: w_next_pc = branch_taken ? branch_target : w_pc_plus4;
            PC_SRC_JUMP:   w_next_pc = {r_pc[ADDR_W-1:28], jump_index, 2'b00};
            PC_SRC_JR:     w_next_pc = {w_kernel & jr_target[ADDR_W-1], jr_target[ADDR_W-2:0]};
            PC_SRC_ILLOP:  w_next_pc = ILLOP_ADDR[ADDR_W-1:0];
            PC_SRC_ERET:   w_next_pc = r_epc;
            default:       w_next_pc = START_ADDR[ADDR_W-1:0];
        endcase
        if (irq_take) w_next_pc = XADR_ADDR[ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= START_ADDR[ADDR_W-1:0];
            r_epc <= '0;
        end else if (advance) begin
            r_pc <= w_next_pc;
            if (w_illop)       r_epc <= w_pc_plus4;
            else if (irq_take) r_epc <= r_pc;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign epc      = r_epc;
    assign kernel   = w_kernel;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, PC width (29..32).
- IRQ_N, 4, interrupt lines (1..8).
- START_ADDR, 32'h00000000, reset vector.
- ILLOP_ADDR, 32'h80000004, illegal-op vector.
- XADR_ADDR, 32'h80000008, interrupt vector.
REQ-002 Ports SHALL be (name, direction, width, meaning); one clock; reset is synchronous and active-high:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- advance  in  1  PC may update this cycle (memory-stall handshake).
- pc_src  in  3  0 seq, 1 branch, 2 jump, 3 jr, 4 illop, 5 eret, 6/7 reserved.
- branch_taken  in  1  condition result for pc_src=1.
- branch_target  in  ADDR_W  conditional-branch target.
- jump_index  in  26  J-format index field.
- jr_target  in  ADDR_W  register jump target.
- irq_in  in  IRQ_N  level interrupt sources.
- irq_en  in  IRQ_N  per-line enable.
- pc  out  ADDR_W  current PC.
- pc_plus4  out  ADDR_W  link value.
- epc  out  ADDR_W  exception return address.
- kernel  out  1  equals pc[ADDR_W-1].
- irq_take  out  1  combinational; interrupt accepted this cycle, CPU suppresses write-back.
- irq_cause  out  3  index of the accepted line, valid while irq_take=1.

Function
REQ-003 pc_plus4 SHALL be {pc[ADDR_W-1], pc[ADDR_W-2:0]+4}, wrapping inside the low field; the MSB is never carried into.
REQ-004 Next PC by pc_src:
- 0: pc_plus4.
- 1: branch_target if branch_taken, else pc_plus4.
- 2: {pc[ADDR_W-1:28], jump_index, 2'b00}.
- 3: jr_target; in user mode (kernel=0) its MSB is forced to 0.
- 4: ILLOP_ADDR.
- 5: epc.
- 6/7: START_ADDR.
REQ-005 pc SHALL load next PC on a clock edge only when advance=1; otherwise pc and epc hold.
REQ-006 Each line SHALL keep a previous-level register and a pending bit. A 0->1 edge of irq_in sets pending, regardless of advance or irq_en.
REQ-007 irq_take=1 iff advance=1, kernel=0, pc_src!=4, and (pending & irq_en)!=0.
REQ-008 On irq_take, irq_cause SHALL be the lowest-index enabled pending line. Next PC = XADR_ADDR, epc <= pc, and that pending bit clears.
REQ-009 On pc_src=4 with advance=1, epc <= pc_plus4. Illegal-op has priority over interrupts.
REQ-010 Interrupts SHALL never be taken while kernel=1; pending bits are retained until user mode.
REQ-011 A new edge on a line in the same cycle its pending bit is cleared SHALL leave the bit set.
REQ-012 pc_src=5 SHALL NOT modify epc. Nesting is not supported; a second exception overwrites epc.

Reset
REQ-013 On reset=1 at a clock edge, regardless of advance or pc_src:
- pc=START_ADDR, epc=0, pending=0, previous levels=0.
- Consequently irq_take=0 in the following cycle.
REQ-014 Reset mid-stall or while an interrupt is pending SHALL discard all pending state; there is no deferred vectoring.

Structure
REQ-015 Package cpu_pkg SHALL hold the pc_src encodings and the START/ILLOP/XADR vector constants, shared with the controller.
REQ-016 Pending registers, edge detect and the priority encoder SHALL live in one sub-module, irq_arbiter, parametrised by IRQ_N.

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- Reset, then 3 cycles pc_src=0 with advance=1 -> pc = 0x0, 0x4, 0x8, 0xC.
- pc=0x7FFFFFFC, pc_src=0 -> pc=0x00000000; pc=0xFFFFFFFC -> pc=0x80000000 (MSB preserved).
- pc=0x100, irq_en=4'b0110, pulse irq_in[2] then irq_in[1] -> first take: cause=1, pc=0x80000008, epc=0x100. Line 2 stays pending until pc_src=5 returns to 0x100, then is taken with cause=2.
- advance=0 for 5 cycles with pc_src=2 -> pc holds. An irq edge during the stall is taken on the first advance=1 cycle.
- pc=0x40 user mode, pc_src=3, jr_target=0x80000010 -> pc=0x00000010. Same from kernel mode -> pc=0x80000010.
- pc=0x200, pc_src=4 with an interrupt simultaneously pending -> pc=0x80000004, epc=0x204, irq_take=0, pending retained.
